// File: rtl/reg_bank.sv
// Register bank with one write port and two registered, zero-gated read ports.
// Read outputs are zero when not enabled, so they can be OR-combined onto a shared bus.
module reg_bank #(
    parameter int BIT_WIDTH = 8,
    parameter int SEL_WIDTH = 3,
    parameter int BYPASS    = 1,
    localparam int REG_COUNT = 2 ** SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 we,
    input  logic [SEL_WIDTH-1:0] wsel,
    input  logic [BIT_WIDTH-1:0] wdata,
    input  logic                 re_a,
    input  logic [SEL_WIDTH-1:0] rsel_a,
    input  logic                 re_b,
    input  logic [SEL_WIDTH-1:0] rsel_b,
    output logic [BIT_WIDTH-1:0] rdata_a,
    output logic [BIT_WIDTH-1:0] rdata_b,
    output logic [REG_COUNT-1:0] wr_onehot,
    output logic [REG_COUNT-1:0] valid
);

    logic [BIT_WIDTH-1:0] regs_q [REG_COUNT];
    logic [BIT_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] valid_q, valid_d;
    logic [REG_COUNT-1:0] onehot_q, onehot_d;
    logic [BIT_WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [BIT_WIDTH-1:0] rdata_b_q, rdata_b_d;

    logic [REG_COUNT-1:0] wr_dec;
    logic [REG_COUNT-1:0] wr_qual;

    // Raw one-hot write decode; clr masks it so a clearing edge never writes.
    always_comb begin
        wr_dec       = '0;
        wr_dec[wsel] = we;
        wr_qual      = clr ? '0 : wr_dec;
    end

    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (clr) begin
                regs_d[i] = '0;
            end else if (wr_qual[i]) begin
                regs_d[i] = wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        valid_d  = clr ? '0 : (valid_q | wr_qual);
        onehot_d = wr_qual;
    end

    // A forwarded read uses wr_qual, so a clearing edge also disables forwarding.
    always_comb begin
        rdata_a_d = '0;
        if (re_a && !clr) begin
            if ((BYPASS != 0) && wr_qual[rsel_a]) begin
                rdata_a_d = wdata;
            end else begin
                rdata_a_d = regs_q[rsel_a];
            end
        end
    end

    always_comb begin
        rdata_b_d = '0;
        if (re_b && !clr) begin
            if ((BYPASS != 0) && wr_qual[rsel_b]) begin
                rdata_b_d = wdata;
            end else begin
                rdata_b_d = regs_q[rsel_b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            valid_q   <= '0;
            onehot_q  <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign wr_onehot = onehot_q;
    assign valid     = valid_q;

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the CPU datapath. It has one write port and two read ports, with one-hot decoded write enables. It replaces hand-wired fixed 3-to-8 decoders and 1-bit zeroing switches with a single clocked block. Read outputs are registered and zero-gated when not enabled, so they can be OR-combined onto the shared data bus.

## Interface
- BIT_WIDTH, 8, data width of every register and port
- SEL_WIDTH, 3, address width; register count REG_COUNT = 2**SEL_WIDTH
- BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address; 0 = read returns the pre-write value
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of all registers
- we  input  1  write enable
- wsel  input  SEL_WIDTH  write address
- wdata  input  BIT_WIDTH  write data
- re_a  input  1  read enable, port A
- rsel_a  input  SEL_WIDTH  read address, port A
- re_b  input  1  read enable, port B
- rsel_b  input  SEL_WIDTH  read address, port B
- rdata_a  output  BIT_WIDTH  registered read data, port A
- rdata_b  output  BIT_WIDTH  registered read data, port B
- wr_onehot  output  REG_COUNT  registered one-hot copy of the write decode of the last edge
- valid  output  REG_COUNT  bit i set once register i has been written since reset/clear

## Operation
- Write decode: combinational one-hot of wsel, qualified by we. At most one bit is set. The decode is all-zero when we=0.
- On a rising edge with we=1 and clr=0: reg[wsel] <= wdata and valid[wsel] <= 1.
- On a rising edge with clr=1: all registers <= 0 and valid <= 0. wr_onehot <= 0 and no write occurs. clr overrides we.
- Read port A, on each rising edge:
  - re_a=0: rdata_a <= 0.
  - re_a=1: rdata_a <= reg[rsel_a].
  - Forwarding: if BYPASS=1, we=1, clr=0 and wsel==rsel_a, rdata_a <= wdata instead.
  - clr=1 with re_a=1: rdata_a <= 0 regardless of BYPASS.
- Read port B: identical rules using re_b/rsel_b.
- Both ports may read the same address in the same cycle. Both get the same value.
- wr_onehot <= the qualified write decode on every edge (all-zero when we=0 or clr=1).
- Unused or illegal input combinations do not exist: every address is in range by construction.

## Timing
- Reset (rst high, asynchronous):
  - all registers, rdata_a, rdata_b, wr_onehot and valid go to 0 immediately, without waiting for clk;
  - the block stays in that state while rst is high.
- First capture after reset: the first rising edge after rst deasserts captures inputs normally.
- Write latency: data is present in reg[wsel] after 1 edge. A read issued on the following cycle returns it 1 edge later.
- Read latency: 1 cycle. rdata reflects the enable/address sampled at the previous edge.
- Same-cycle write+read to the same address:
  - BYPASS=1: new data appears on rdata after 1 edge.
  - BYPASS=0: old data appears; new data is readable on the next access.
- Outputs hold their value between edges. rdata is never X after reset.
- Reset asserted mid-write: the write is lost and the register reads 0.

## Test plan
- Reset: drive rst=1 mid-cycle with non-zero registers -> rdata_a, rdata_b, wr_onehot, valid = 0 before the next edge; re_a=1, rsel_a=5 after release -> rdata_a=0x00.
- Write/read all: BIT_WIDTH=8, SEL_WIDTH=3; write reg i = 0x10+i for i=0..7, then read each on port A and reg 7-i on port B -> port A reads 0x10..0x17 and port B reads 0x17..0x10 in order; valid=0xFF; wr_onehot walks 0x01..0x80 during the writes.
- Gating: re_a=0 with rsel_a=3 holding 0x13 -> rdata_a=0x00 on the next edge; re_a=1 -> 0x13 on the following edge.
- Bypass: reg2=0x22; same cycle we=1, wsel=2, wdata=0x5A, re_a=1, rsel_a=2 -> with BYPASS=1, rdata_a=0x5A after 1 edge; with BYPASS=0, rdata_a=0x22, and a next-cycle read gives 0x5A.
- Clear priority: clr=1 and we=1, wsel=4, wdata=0xFF -> all registers 0, valid=0, wr_onehot=0; reading reg4 next cycle -> 0x00.
- Width generality: BIT_WIDTH=16, SEL_WIDTH=2; write reg3=0xBEEF and read it on both ports simultaneously -> rdata_a = rdata_b = 0xBEEF, wr_onehot=4'b1000.
